c5g_dmaster_packets_to_bytes: RTL and testbench

//  Serialises the debug master's channelised Avalon-ST packet stream into a flat byte stream.

---
 rtl/c5g_dmaster_packets_to_bytes.sv | 121 ++++++++++++
 tb/tb_c5g_dmaster_packets_to_bytes.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c5g_dmaster_packets_to_bytes.sv
// Packet-to-byte serialiser for the debug master.
// Turns channelised Avalon-ST beats into a flat byte stream with in-band
// markers: SOP 0x7A, EOP 0x7B, CHANNEL 0x7C, ESCAPE 0x7D. Any channel or
// payload byte that collides with a marker goes out as 0x7D, byte ^ 0x20.
module c5g_dmaster_packets_to_bytes #(
  parameter int CHANNEL_WIDTH  = 8,
  parameter bit CHAN_EVERY_SOP = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic [CHANNEL_WIDTH-1:0] in_channel,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data
);

  typedef enum logic [2:0] {
    IDLE, CH_MARK, CH_ESC, CH_BYTE, SOP_MARK, EOP_MARK, D_ESC, D_BYTE
  } state_t;

  state_t     state_reg;
  logic [7:0] data_reg;
  logic [7:0] chan_reg;
  logic       sop_reg;
  logic       eop_reg;
  logic [7:0] last_chan_reg;
  logic       chan_known_reg;

  // True for bytes that collide with one of the four marker codes.
  function automatic logic is_special(input logic [7:0] b);
    return (b >= 8'h7A) && (b <= 8'h7D);
  endfunction

  // First symbol of a beat once the channel group (if any) is out of the way.
  function automatic state_t after_chan(input logic sop, input logic eop,
                                        input logic [7:0] d);
    if (sop)
      return SOP_MARK;
    else if (eop)
      return EOP_MARK;
    else if (is_special(d))
      return D_ESC;
    else
      return D_BYTE;
  endfunction

  logic [7:0] in_chan8;
  logic       chan_needed;
  logic       accept;
  logic       advance;
  state_t     first_state;

  assign in_chan8    = 8'(in_channel);
  assign chan_needed = !chan_known_reg || (in_chan8 != last_chan_reg) ||
                       (CHAN_EVERY_SOP && in_startofpacket);
  assign first_state = chan_needed ? CH_MARK
                                   : after_chan(in_startofpacket, in_endofpacket, in_data);

  // A new beat can be taken while idle, or in the same cycle the last data
  // byte of the current beat is handed off; this keeps mid-packet bytes at
  // one per clock.
  assign in_ready  = (state_reg == IDLE) || ((state_reg == D_BYTE) && out_ready);
  assign out_valid = (state_reg != IDLE);
  assign accept    = in_valid && in_ready;
  assign advance   = out_valid && out_ready;

  // Symbol sequencer: capture beats and walk through the symbols each needs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      data_reg       <= 8'h00;
      chan_reg       <= 8'h00;
      sop_reg        <= 1'b0;
      eop_reg        <= 1'b0;
      last_chan_reg  <= 8'h00;
      chan_known_reg <= 1'b0;
    end else if (accept) begin
      data_reg  <= in_data;
      chan_reg  <= in_chan8;
      sop_reg   <= in_startofpacket;
      eop_reg   <= in_endofpacket;
      state_reg <= first_state;
      // Channel tracking is updated as the channel marker is scheduled.
      if (chan_needed) begin
        last_chan_reg  <= in_chan8;
        chan_known_reg <= 1'b1;
      end
    end else if (advance) begin
      case (state_reg)
        CH_MARK:  state_reg <= is_special(chan_reg) ? CH_ESC : CH_BYTE;
        CH_ESC:   state_reg <= CH_BYTE;
        CH_BYTE:  state_reg <= after_chan(sop_reg, eop_reg, data_reg);
        SOP_MARK: state_reg <= after_chan(1'b0, eop_reg, data_reg);
        EOP_MARK: state_reg <= after_chan(1'b0, 1'b0, data_reg);
        D_ESC:    state_reg <= D_BYTE;
        default:  state_reg <= IDLE;
      endcase
    end
  end

  // Output byte is a pure function of the state and the held beat, so it
  // cannot change while the downstream stalls.
  always_comb begin
    out_data = 8'h00;
    case (state_reg)
      CH_MARK:       out_data = 8'h7C;
      CH_ESC, D_ESC: out_data = 8'h7D;
      CH_BYTE:       out_data = chan_reg ^ (is_special(chan_reg) ? 8'h20 : 8'h00);
      SOP_MARK:      out_data = 8'h7A;
      EOP_MARK:      out_data = 8'h7B;
      D_BYTE:        out_data = data_reg ^ (is_special(data_reg) ? 8'h20 : 8'h00);
      default:       out_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_c5g_dmaster_packets_to_bytes.sv
// Self-checking bench for c5g_dmaster_packets_to_bytes.
module tb_c5g_dmaster_packets_to_bytes;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_ready;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_sop = 1'b0;
  logic       in_eop = 1'b0;
  logic [7:0] in_channel = 8'h00;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  c5g_dmaster_packets_to_bytes dut (
    .clk              (clk),
    .reset            (rst),
    .in_ready         (in_ready),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_startofpacket (in_sop),
    .in_endofpacket   (in_eop),
    .in_channel       (in_channel),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_data         (out_data)
  );

  int         errors = 0;
  int         checks = 0;
  longint     cyc = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  longint     got_cyc[$];
  bit         rand_ready = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         irdy_low = 0;

  // Reference encoder state: which channel the receiver currently believes in.
  bit         m_known = 1'b0;
  logic [7:0] m_last = 8'h00;

  typedef struct {
    logic [7:0]  ch;
    logic [7:0]  d;
    logic        s;
    logic        e;
    int          n;
    logic [63:0] bytes;   // expected output, first byte in the top octet
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: encode one beat straight from the framing rules.
  function automatic void push_esc(input logic [7:0] b);
    if (b >= 8'h7A && b <= 8'h7D) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(b ^ 8'h20);
    end else begin
      exp_q.push_back(b);
    end
  endfunction

  function automatic void model_beat(input logic [7:0] ch, input logic [7:0] d,
                                     input logic s, input logic e);
    if (!m_known || ch != m_last) begin
      exp_q.push_back(8'h7C);
      push_esc(ch);
      m_last  = ch;
      m_known = 1'b1;
    end
    if (s) exp_q.push_back(8'h7A);
    if (e) exp_q.push_back(8'h7B);
    push_esc(d);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: record every handshake and verify outputs hold during stalls.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", 32'(out_valid), 32'd1);
        check("stall_data_hold", 32'(out_data), 32'(prev_data));
      end
      if (in_valid && !in_ready) irdy_low++;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic drive_ready();
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Called and returns just after a rising edge; holds the beat until taken.
  task automatic send_beat(input logic [7:0] ch, input logic [7:0] d,
                           input logic s, input logic e);
    int  n = 0;
    bit  done = 1'b0;
    in_valid   = 1'b1;
    in_channel = ch;
    in_data    = d;
    in_sop     = s;
    in_eop     = e;
    drive_ready();
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      if (!done) begin
        n++;
        if (n > 200) begin
          check("send_beat_timeout", 32'd1, 32'd0);
          done = 1'b1;
        end
        drive_ready();
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  // Wait for the serialiser to drain; returns just after a rising edge.
  task automatic wait_idle();
    int n = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (!out_valid) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 500) begin
        check("wait_idle_timeout", 32'd1, 32'd0);
        done = 1'b1;
      end
      drive_ready();
    end
  endtask

  task automatic compare_stream(input string name);
    int n;
    check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    logic [7:0] chs[4];
    int         nbeats;
    int         len;
    int         npkt;
    logic [7:0] d;
    logic [7:0] ch;
    int         span;

    tbl[0] = '{8'h00, 8'h41, 1'b1, 1'b1, 5, 64'h7C007A7B41000000};
    tbl[1] = '{8'h00, 8'h10, 1'b1, 1'b0, 2, 64'h7A10000000000000};
    tbl[2] = '{8'h00, 8'h7A, 1'b0, 1'b0, 2, 64'h7D5A000000000000};
    tbl[3] = '{8'h00, 8'h20, 1'b0, 1'b1, 2, 64'h7B20000000000000};
    tbl[4] = '{8'h7D, 8'h7B, 1'b1, 1'b1, 7, 64'h7C7D5D7A7B7D5B00};
    chs[0] = 8'h00; chs[1] = 8'h01; chs[2] = 8'h7C; chs[3] = 8'h7D;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid_after", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // T1..T3: table-driven single beats with fixed expected byte strings
    for (int v = 0; v < 5; v++) begin
      send_beat(tbl[v].ch, tbl[v].d, tbl[v].s, tbl[v].e);
      model_beat(tbl[v].ch, tbl[v].d, tbl[v].s, tbl[v].e);
      wait_idle();
      exp_q.delete();
      for (int i = 0; i < tbl[v].n; i++)
        exp_q.push_back(tbl[v].bytes[63 - 8*i -: 8]);
      $display("vec %0d: ch=%02h data=%02h sop=%0b eop=%0b -> %0d bytes",
               v, tbl[v].ch, tbl[v].d, tbl[v].s, tbl[v].e, got_q.size());
      compare_stream($sformatf("vec%0d", v));
      check($sformatf("vec%0d_in_ready_idle", v), 32'(in_ready), 32'd1);
    end

    // T4: random packets with 50% downstream backpressure
    rand_ready = 1'b1;
    nbeats = 0;
    npkt   = 0;
    while (nbeats < 1000) begin
      len = $urandom_range(1, 8);
      ch  = chs[$urandom_range(0, 3)];
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) d = 8'h7A + 8'($urandom_range(0, 3));
        else d = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) begin
          @(posedge clk);
          #1;
          drive_ready();
        end
        send_beat(ch, d, k == 0, k == len - 1);
        model_beat(ch, d, k == 0, k == len - 1);
        nbeats++;
      end
      npkt++;
      $display("t4 packet %0d: ch=%02h len=%0d", npkt, ch, len);
    end
    wait_idle();
    compare_stream("t4");
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    // T5: 64 mid-packet bytes on an established channel run at one per clock
    send_beat(8'h03, 8'h55, 1'b1, 1'b0);
    model_beat(8'h03, 8'h55, 1'b1, 1'b0);
    wait_idle();
    compare_stream("t5_setup");
    irdy_low = 0;
    for (int i = 0; i < 64; i++) begin
      send_beat(8'h03, 8'(i), 1'b0, 1'b0);
      model_beat(8'h03, 8'(i), 1'b0, 1'b0);
    end
    wait_idle();
    check("t5_count", 32'(got_cyc.size()), 32'd64);
    span = (got_cyc.size() == 64) ? int'(got_cyc[63] - got_cyc[0]) : -1;
    check("t5_span_cycles", 32'(span), 32'd63);
    check("t5_in_ready_low", 32'(irdy_low), 32'd0);
    $display("t5: 64 bytes over %0d cycle span", span + 1);
    compare_stream("t5");

    // T6: asynchronous reset while the escape byte is being held
    out_ready = 1'b0;
    send_beat(8'h03, 8'h7D, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_in_desc_valid", 32'(out_valid), 32'd1);
    check("t6_in_desc_data", 32'(out_data), 32'h7D);
    #2;
    rst = 1'b1;
    #1;
    check("t6_reset_out_valid", 32'(out_valid), 32'd0);
    check("t6_reset_out_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    m_known = 1'b0;
    m_last  = 8'h00;
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
    send_beat(8'h03, 8'h44, 1'b1, 1'b1);
    model_beat(8'h03, 8'h44, 1'b1, 1'b1);
    wait_idle();
    check("t6_first_byte", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hFFFF, 32'h7C);
    $display("t6: post-reset beat -> %0d bytes", got_q.size());
    compare_stream("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
